// File: rtl/fifo_wr_status.sv
// Write-side status generator for an async FIFO.
// Synchronizes the read-domain Gray pointer into the write clock and derives
// registered full, almost_full, fill level and a sticky overflow flag from the
// same next-pointer value the write pointer block will load.
module fifo_wr_status #(
    parameter int ADDR         = 5,
    parameter int AFULL_THRESH = 28,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_op,
    input  logic [ADDR:0] wr_binary,
    input  logic [ADDR:0] rd_gray_async,
    output logic          full,
    output logic          almost_full,
    output logic [ADDR:0] wr_level,
    output logic          overflow
);

    localparam logic [ADDR:0] AFULL_VAL = AFULL_THRESH[ADDR:0];

    // Gray to binary: top bit copied, each lower bit folds in the bit above it.
    function automatic logic [ADDR:0] gray_to_bin(input logic [ADDR:0] gray);
        logic [ADDR:0] bin;
        bin[ADDR] = gray[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

    // Binary to Gray for the next write pointer.
    function automatic logic [ADDR:0] bin_to_gray(input logic [ADDR:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    logic [ADDR:0] sync_r [SYNC_STAGES];
    logic [ADDR:0] rd_gray_s;
    logic [ADDR:0] rd_bin_s;
    logic          accept_s;
    logic [ADDR:0] wr_next_s;
    logic [ADDR:0] wr_gray_next_s;
    logic [ADDR:0] full_match_s;
    logic [ADDR:0] level_next_s;
    logic          full_next_s;
    logic          afull_next_s;

    logic          full_r;
    logic          almost_full_r;
    logic [ADDR:0] wr_level_r;
    logic          overflow_r;

    // Plain flop chain carrying the read Gray pointer into the write clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= {(ADDR + 1){1'b0}};
            end
        end else begin
            sync_r[0] <= rd_gray_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s - 1];
            end
        end
    end

    assign rd_gray_s = sync_r[SYNC_STAGES - 1];
    assign rd_bin_s  = gray_to_bin(rd_gray_s);

    // Next-state status computed from the pointer the write block is about to load.
    always_comb begin
        accept_s       = wr_op & ~full_r;
        wr_next_s      = wr_binary + {{ADDR{1'b0}}, accept_s};
        wr_gray_next_s = bin_to_gray(wr_next_s);
        // Full when the next write Gray pointer equals the read Gray pointer
        // with its two top bits inverted (one full lap ahead).
        full_match_s   = {~rd_gray_s[ADDR:ADDR-1], rd_gray_s[ADDR-2:0]};
        full_next_s    = (wr_gray_next_s == full_match_s);
        level_next_s   = wr_next_s - rd_bin_s;
        afull_next_s   = (level_next_s >= AFULL_VAL);
    end

    // Status registers; overflow is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
            wr_level_r    <= {(ADDR + 1){1'b0}};
            overflow_r    <= 1'b0;
        end else begin
            full_r        <= full_next_s;
            almost_full_r <= afull_next_s;
            wr_level_r    <= level_next_s;
            overflow_r    <= overflow_r | (wr_op & full_r);
        end
    end

    assign full        = full_r;
    assign almost_full = almost_full_r;
    assign wr_level    = wr_level_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_fifo_wr_status.sv
// Directed self-checking bench for fifo_wr_status at default parameters.
// A small behavioural write pointer block drives wr_binary, advancing on
// wr_op while full is low, with an optional preload for the wrap scenario.
module tb_fifo_wr_status;

    localparam int ADDR = 5;

    logic          clk;
    logic          reset;
    logic          wr_op;
    logic [ADDR:0] wr_binary;
    logic [ADDR:0] rd_gray_async;
    logic          full;
    logic          almost_full;
    logic [ADDR:0] wr_level;
    logic          overflow;

    logic          load_en;
    logic [ADDR:0] load_val;

    int n_checks;
    int n_fail;

    fifo_wr_status #(
        .ADDR         (5),
        .AFULL_THRESH (28),
        .SYNC_STAGES  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_op         (wr_op),
        .wr_binary     (wr_binary),
        .rd_gray_async (rd_gray_async),
        .full          (full),
        .almost_full   (almost_full),
        .wr_level      (wr_level),
        .overflow      (overflow)
    );

    // Write clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural write pointer block.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_binary <= 6'd0;
        end else if (load_en) begin
            wr_binary <= load_val;
        end else if (wr_op && !full) begin
            wr_binary <= wr_binary + 6'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Checked before the first clock edge.
        #2;
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_checks++;
        if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
        n_checks++;
        if (wr_level !== 6'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", wr_level); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_fill();
        logic exp_af;
        logic exp_full;
        wr_op = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            exp_af   = (k >= 28);
            exp_full = (k == 32);
            n_checks++;
            if (wr_level !== 6'(k)) begin n_fail++; $display("FAIL fill_level k=%0d got=%0d exp=%0d", k, wr_level, k); end
            n_checks++;
            if (almost_full !== exp_af) begin n_fail++; $display("FAIL fill_afull k=%0d got=%b exp=%b", k, almost_full, exp_af); end
            n_checks++;
            if (full !== exp_full) begin n_fail++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, full, exp_full); end
            n_checks++;
            if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow k=%0d got=%b exp=0", k, overflow); end
        end
    endtask

    task automatic test_overflow();
        wr_op = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (wr_binary !== 6'd32) begin n_fail++; $display("FAIL ovf_ptr k=%0d got=%0d exp=32", k, wr_binary); end
            n_checks++;
            if (wr_level !== 6'd32) begin n_fail++; $display("FAIL ovf_level k=%0d got=%0d exp=32", k, wr_level); end
            n_checks++;
            if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full k=%0d got=%b exp=1", k, full); end
            n_checks++;
            if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag k=%0d got=%b exp=1", k, overflow); end
        end
        wr_op = 1'b0;
        tick();
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_drain();
        rd_gray_async = 6'd6;      // gray(4)
        tick();
        tick();
        n_checks++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL drain_early_full got=%b exp=1", full); end
        n_checks++;
        if (wr_level !== 6'd32) begin n_fail++; $display("FAIL drain_early_level got=%0d exp=32", wr_level); end
        tick();
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL drain_full got=%b exp=0", full); end
        n_checks++;
        if (wr_level !== 6'd28) begin n_fail++; $display("FAIL drain_level got=%0d exp=28", wr_level); end
        n_checks++;
        if (almost_full !== 1'b1) begin n_fail++; $display("FAIL drain_afull got=%b exp=1", almost_full); end
        rd_gray_async = 6'd7;      // gray(5)
        tick();
        tick();
        tick();
        n_checks++;
        if (wr_level !== 6'd27) begin n_fail++; $display("FAIL drain2_level got=%0d exp=27", wr_level); end
        n_checks++;
        if (almost_full !== 1'b0) begin n_fail++; $display("FAIL drain2_afull got=%b exp=0", almost_full); end
    endtask

    task automatic test_wrap_full();
        rd_gray_async = 6'd60;     // gray(40)
        load_val      = 6'd7;
        load_en       = 1'b1;
        tick();
        load_en = 1'b0;
        tick();
        tick();
        // Settled, idle: level = 7 - 40 mod 64 = 31, not full.
        n_checks++;
        if (wr_level !== 6'd31) begin n_fail++; $display("FAIL wrap_pre_level got=%0d exp=31", wr_level); end
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_pre_full got=%b exp=0", full); end
        wr_op = 1'b1;
        tick();
        wr_op = 1'b0;
        n_checks++;
        if (wr_binary !== 6'd8) begin n_fail++; $display("FAIL wrap_ptr got=%0d exp=8", wr_binary); end
        n_checks++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got=%b exp=1", full); end
        n_checks++;
        if (wr_level !== 6'd32) begin n_fail++; $display("FAIL wrap_level got=%0d exp=32", wr_level); end
        n_checks++;
        if (almost_full !== 1'b1) begin n_fail++; $display("FAIL wrap_afull got=%b exp=1", almost_full); end
    endtask

    task automatic test_async_reset();
        // Ensure overflow is set while full.
        wr_op = 1'b1;
        tick();
        wr_op = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre got full=%b ovf=%b exp 1 1", full, overflow);
        end
        #2;
        reset         = 1'b1;
        rd_gray_async = 6'd0;
        #1;
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL areset_full got=%b exp=0", full); end
        n_checks++;
        if (almost_full !== 1'b0) begin n_fail++; $display("FAIL areset_afull got=%b exp=0", almost_full); end
        n_checks++;
        if (wr_level !== 6'd0) begin n_fail++; $display("FAIL areset_level got=%0d exp=0", wr_level); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL areset_overflow got=%b exp=0", overflow); end
        tick();
        reset = 1'b0;
        wr_op = 1'b1;
        tick();
        tick();
        wr_op = 1'b0;
        n_checks++;
        if (wr_level !== 6'd2) begin n_fail++; $display("FAIL resume_level got=%0d exp=2", wr_level); end
        n_checks++;
        if (full !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL resume_flags got full=%b ovf=%b exp 0 0", full, overflow);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        wr_op         = 1'b0;
        rd_gray_async = 6'd0;
        load_en       = 1'b0;
        load_val      = 6'd0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap_full();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
